execute_unit: RTL and testbench
===============================

# execute_unit

Execute stage of the pipelined MIPS datapath, sitting directly downstream of the ID/EX pipeline register and consuming its control and data outputs. Single-cycle ALU for addi and beq/bne branch resolution; an iterative 32-cycle divider for R-type div, stalling upstream while it runs. Produces the write-back result, destination register and branch redirect for the EX/MEM stage.

## Interface
Parameters:
- DIV_CYCLES, 32, number of divide iterations; fixed at the data width.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- Flush  in  1  abort current op, drop outputs.
- OpCode_in  in  6  instruction opcode.
- ALUOp  in  2  01 add, 11 branch compare, 10 divide, 00 bubble.
- RegDst  in  1  1: dest = SignExtend_in[15:11], 0: dest = Rt_in.
- ALUSrc  in  1  1: operand B = SignExtend_in, 0: ReadData2_in.
- PC_Plus_4_in, ReadData1_in, ReadData2_in, SignExtend_in  in  32 each.
- Rt_in  in  5  instruction bits 20:16.
- Result  out  32  ALU sum or quotient.
- WriteReg  out  5  destination register.
- RegWrite  out  1  result must be written back.
- Valid  out  1  one-cycle pulse: outputs describe a completed op.
- BranchTaken  out  1  redirect fetch.
- BranchTarget  out  32  PC_Plus_4_in + (SignExtend_in << 2).
- DivByZero  out  1  completed div had zero divisor.
- Stall  out  1  combinational; upstream holds its register while high.

## Operation
- Reset: all outputs 0, state IDLE, divider registers 0.
- States: IDLE, DIV_RUN. Op class decoded from ALUOp only (opcode 0 with ALUOp 00 is a bubble).
- IDLE, ALUOp 01: Result = ReadData1_in + B, modulo 2^32, no overflow trap; RegWrite=1, Valid=1.
- IDLE, ALUOp 11: equal = (ReadData1_in == ReadData2_in); BranchTaken = equal for opcode 000100, !equal for 000101, 0 otherwise; BranchTarget registered; RegWrite=0, Valid=1.
- IDLE, ALUOp 10, divisor ReadData2_in != 0: latch operands and WriteReg, counter = 31, go DIV_RUN.
- IDLE, ALUOp 10, divisor 0: no run; Result=32'hFFFFFFFF, DivByZero=1, RegWrite=1, Valid=1 at that posedge.
- DIV_RUN: one restoring shift-subtract iteration per cycle; counter decrements; at counter 0 register quotient to Result, RegWrite=1, Valid=1, return IDLE. Inputs ignored in DIV_RUN.
- ALUOp 00: Valid, RegWrite, BranchTaken, DivByZero all 0.
- Stall = !Flush & ((IDLE & ALUOp==10 & ReadData2_in!=0) | (DIV_RUN & counter!=0)).
- Flush at posedge (any state): state IDLE, Valid/RegWrite/BranchTaken/DivByZero 0; Result, WriteReg hold. Flush wins over every other event.
- Reset_n low mid-divide: immediate return to IDLE, all outputs 0.

## Timing
- Non-div ops: presented in cycle N, outputs valid after posedge ending N; Valid high exactly one cycle.
- Div: accept at end of cycle A; iterations in A+1..A+32; result after posedge ending A+32 (33-cycle latency). Stall high cycles A..A+31, low in A+32 so upstream loads the next instruction at that cycle's negedge.
- Back-to-back divs: second div accepted at end of A+33.
- Div-by-zero: single cycle, Stall never high.

## Configuration
- EXECUTE_UNIT_SIGNED_DIV_EN defined: operands two's complement; divide magnitudes, quotient negated when signs differ (truncate toward zero); 0x80000000 / -1 = 0x80000000.
- Undefined: unsigned division; 0xFFFFFFFF / 2 = 0x7FFFFFFF.

## Structure
- Package execute_pkg: opcode constants (ADDI 001000, BEQ 000100, BNE 000101, RTYPE 000000), ALUOp encodings, state enum.
- Sub-module execute_divider: operand latch, shift-subtract datapath, counter, sign fix-up; top holds decode, ALU, branch logic, output registers.

## Test plan
- ALUOp 01, ALUSrc=1, ReadData1=5, SignExtend=0xFFFFFFFD, Rt=8 -> Result=2, WriteReg=8, RegWrite=1, Valid one cycle.
- Opcode 000100, ReadData1=ReadData2=7, PC_Plus_4=0x100, SignExtend=4 -> BranchTaken=1, BranchTarget=0x110; opcode 000101 same data -> BranchTaken=0.
- ALUOp 10, 100/7, RegDst=1, SignExtend[15:11]=3 -> Stall high 32 cycles, Result=14, WriteReg=3, Valid 33 cycles after accept.
- ALUOp 10, divisor 0 -> next cycle Result=0xFFFFFFFF, DivByZero=1, Stall never asserted.
- Signed build: -100/7 -> Result=0xFFFFFFF2 (-14); unsigned build 0xFFFFFFFF/2 -> 0x7FFFFFFF.
- Flush at iteration 10 of a divide -> Stall low same cycle, state IDLE, no Valid pulse; following addi completes normally.

Source files
------------

// File: rtl/execute_pkg.sv
// Shared constants and types for the MIPS execute stage: opcodes, ALUOp
// encodings, sequencer states and operand helpers.
package execute_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101,
        OP_ADDI  = 6'b001000
    } opcode_e;

    typedef enum logic [1:0] {
        ALU_BUBBLE = 2'b00,
        ALU_ADD    = 2'b01,
        ALU_DIV    = 2'b10,
        ALU_BRANCH = 2'b11
    } alu_op_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_DIV_RUN = 1'b1
    } state_e;

    // Two's-complement magnitude; 0x80000000 maps onto itself, which the
    // unsigned datapath then treats as 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/execute_unit_if.sv
// ID/EX-facing bundle of the execute stage: decoded controls and operands in,
// write-back result, branch redirect and stall out.
interface execute_unit_if;
    logic        Flush;
    logic [5:0]  OpCode_in;
    logic [1:0]  ALUOp;
    logic        RegDst;
    logic        ALUSrc;
    logic [31:0] PC_Plus_4_in;
    logic [31:0] ReadData1_in;
    logic [31:0] ReadData2_in;
    logic [31:0] SignExtend_in;
    logic [4:0]  Rt_in;
    logic [31:0] Result;
    logic [4:0]  WriteReg;
    logic        RegWrite;
    logic        Valid;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        DivByZero;
    logic        Stall;

    modport master (
        output Flush, OpCode_in, ALUOp, RegDst, ALUSrc, PC_Plus_4_in,
               ReadData1_in, ReadData2_in, SignExtend_in, Rt_in,
        input  Result, WriteReg, RegWrite, Valid, BranchTaken, BranchTarget,
               DivByZero, Stall
    );

    modport slave (
        input  Flush, OpCode_in, ALUOp, RegDst, ALUSrc, PC_Plus_4_in,
               ReadData1_in, ReadData2_in, SignExtend_in, Rt_in,
        output Result, WriteReg, RegWrite, Valid, BranchTaken, BranchTarget,
               DivByZero, Stall
    );
endinterface

// File: rtl/execute_divider.sv
// Iterative restoring divider, one quotient bit per cycle.
// EXECUTE_UNIT_SIGNED_DIV_EN selects truncating signed division, else unsigned.
module execute_divider
    import execute_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic        run,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient
);
    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [31:0]      rem_r;
    logic [31:0]      quo_r;
    logic [31:0]      dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             neg_r;
    logic [32:0]      shifted_s;
    logic [32:0]      trial_s;
    logic [31:0]      rem_next_s;
    logic [31:0]      quo_next_s;
    logic [31:0]      dend_mag_s;
    logic [31:0]      dvs_mag_s;
    logic             neg_s;

`ifdef EXECUTE_UNIT_SIGNED_DIV_EN
    assign dend_mag_s = mag32(dividend);
    assign dvs_mag_s  = mag32(divisor);
    assign neg_s      = dividend[31] ^ divisor[31];
`else
    assign dend_mag_s = dividend;
    assign dvs_mag_s  = divisor;
    assign neg_s      = 1'b0;
`endif

    // One shift-subtract step; a borrow out of bit 32 means the trial failed
    always_comb begin
        shifted_s = {rem_r, quo_r[31]};
        trial_s   = shifted_s - {1'b0, dvs_r};
        if (trial_s[32]) begin
            rem_next_s = shifted_s[31:0];
            quo_next_s = {quo_r[30:0], 1'b0};
        end else begin
            rem_next_s = trial_s[31:0];
            quo_next_s = {quo_r[30:0], 1'b1};
        end
    end

    // The final quotient is taken from the step executing at count zero
    assign last     = (cnt_r == '0);
    assign quotient = neg_r ? (32'd0 - quo_next_s) : quo_next_s;

    // Operand latch on accept, then iterate while the sequencer is running
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rem_r <= 32'd0;
            quo_r <= 32'd0;
            dvs_r <= 32'd0;
            cnt_r <= '0;
            neg_r <= 1'b0;
        end else if (start) begin
            rem_r <= 32'd0;
            quo_r <= dend_mag_s;
            dvs_r <= dvs_mag_s;
            neg_r <= neg_s;
            cnt_r <= CNT_W'(DIV_CYCLES - 1);
        end else if (run) begin
            rem_r <= rem_next_s;
            quo_r <= quo_next_s;
            if (cnt_r != '0) begin
                cnt_r <= cnt_r - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/execute_unit.sv
// MIPS execute stage: addi ALU, beq/bne resolution and a stalling iterative
// divider. EXECUTE_UNIT_SIGNED_DIV_EN enables signed division.
module execute_unit
    import execute_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic          Clk,
    input  logic          Reset_n,
    execute_unit_if.slave eu
);
    state_e      state_r, state_n;
    logic [31:0] result_r, result_n;
    logic [4:0]  write_reg_r, write_reg_n;
    logic [31:0] target_r, target_n;
    logic [4:0]  div_dest_r, div_dest_n;
    logic        reg_write_r, reg_write_n;
    logic        valid_r, valid_n;
    logic        taken_r, taken_n;
    logic        div_zero_r, div_zero_n;
    logic        div_start_s;
    logic        div_run_s;
    logic        div_last_s;
    logic [31:0] div_quot_s;
    logic [4:0]  dest_s;
    logic [31:0] opb_s;
    logic        equal_s;
    logic        div_ok_s;

    assign dest_s    = eu.RegDst ? eu.SignExtend_in[15:11] : eu.Rt_in;
    assign opb_s     = eu.ALUSrc ? eu.SignExtend_in : eu.ReadData2_in;
    assign equal_s   = (eu.ReadData1_in == eu.ReadData2_in);
    assign div_ok_s  = (eu.ReadData2_in != 32'd0);
    assign div_run_s = (state_r == ST_DIV_RUN);

    execute_divider #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (div_start_s),
        .run      (div_run_s),
        .dividend (eu.ReadData1_in),
        .divisor  (eu.ReadData2_in),
        .last     (div_last_s),
        .quotient (div_quot_s)
    );

    // Sequencer next state and next output values; Flush overrides everything
    always_comb begin
        state_n     = state_r;
        result_n    = result_r;
        write_reg_n = write_reg_r;
        target_n    = target_r;
        div_dest_n  = div_dest_r;
        reg_write_n = 1'b0;
        valid_n     = 1'b0;
        taken_n     = 1'b0;
        div_zero_n  = 1'b0;
        div_start_s = 1'b0;
        if (eu.Flush) begin
            state_n = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    case (eu.ALUOp)
                        ALU_ADD: begin
                            result_n    = eu.ReadData1_in + opb_s;
                            write_reg_n = dest_s;
                            reg_write_n = 1'b1;
                            valid_n     = 1'b1;
                        end
                        ALU_BRANCH: begin
                            target_n = eu.PC_Plus_4_in + (eu.SignExtend_in << 2'd2);
                            valid_n  = 1'b1;
                            if (eu.OpCode_in == OP_BEQ) begin
                                taken_n = equal_s;
                            end else if (eu.OpCode_in == OP_BNE) begin
                                taken_n = !equal_s;
                            end else begin
                                taken_n = 1'b0;
                            end
                        end
                        ALU_DIV: begin
                            if (div_ok_s) begin
                                div_start_s = 1'b1;
                                div_dest_n  = dest_s;
                                state_n     = ST_DIV_RUN;
                            end else begin
                                result_n    = 32'hFFFF_FFFF;
                                write_reg_n = dest_s;
                                div_zero_n  = 1'b1;
                                reg_write_n = 1'b1;
                                valid_n     = 1'b1;
                            end
                        end
                        default: begin
                            state_n = ST_IDLE;
                        end
                    endcase
                end
                ST_DIV_RUN: begin
                    if (div_last_s) begin
                        result_n    = div_quot_s;
                        write_reg_n = div_dest_r;
                        reg_write_n = 1'b1;
                        valid_n     = 1'b1;
                        state_n     = ST_IDLE;
                    end else begin
                        state_n = ST_DIV_RUN;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // State and EX/MEM-facing output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= ST_IDLE;
            result_r    <= 32'd0;
            write_reg_r <= 5'd0;
            target_r    <= 32'd0;
            div_dest_r  <= 5'd0;
            reg_write_r <= 1'b0;
            valid_r     <= 1'b0;
            taken_r     <= 1'b0;
            div_zero_r  <= 1'b0;
        end else begin
            state_r     <= state_n;
            result_r    <= result_n;
            write_reg_r <= write_reg_n;
            target_r    <= target_n;
            div_dest_r  <= div_dest_n;
            reg_write_r <= reg_write_n;
            valid_r     <= valid_n;
            taken_r     <= taken_n;
            div_zero_r  <= div_zero_n;
        end
    end

    assign eu.Result       = result_r;
    assign eu.WriteReg     = write_reg_r;
    assign eu.RegWrite     = reg_write_r;
    assign eu.Valid        = valid_r;
    assign eu.BranchTaken  = taken_r;
    assign eu.BranchTarget = target_r;
    assign eu.DivByZero    = div_zero_r;
    // Upstream holds through the last iteration cycle minus one
    assign eu.Stall = !eu.Flush &&
                      (((state_r == ST_IDLE) && (eu.ALUOp == ALU_DIV) && div_ok_s) ||
                       ((state_r == ST_DIV_RUN) && !div_last_s));

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: directed plan cases plus random traffic
// against a behavioural model of the stage.
module tb_execute_unit;
    import execute_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  wr;
        logic        rw;
        logic        bt;
        logic [31:0] tgt;
        logic        dbz;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [31:0] m_res, m_tgt;
    logic [4:0]  m_wr;

    execute_unit_if eu_if();

    execute_unit #(.DIV_CYCLES(32)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .eu      (eu_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
`ifdef EXECUTE_UNIT_SIGNED_DIV_EN
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'($signed(a) / $signed(b));
`else
        return a / b;
`endif
    endfunction

    // Monitor: every Valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (eu_if.Valid === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_valid", {31'd0, eu_if.Valid}, 32'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("result",        eu_if.Result, mon_e.res);
                chk("write_reg",     {27'd0, eu_if.WriteReg}, {27'd0, mon_e.wr});
                chk("reg_write",     {31'd0, eu_if.RegWrite}, {31'd0, mon_e.rw});
                chk("branch_taken",  {31'd0, eu_if.BranchTaken}, {31'd0, mon_e.bt});
                chk("branch_target", eu_if.BranchTarget, mon_e.tgt);
                chk("div_by_zero",   {31'd0, eu_if.DivByZero}, {31'd0, mon_e.dbz});
                chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic drive(input logic [1:0] aop, input logic [5:0] opc, input logic rdst,
                         input logic asrc, input logic [31:0] pc4, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] se, input logic [4:0] rt,
                         input logic fl);
        eu_if.ALUOp         = aop;
        eu_if.OpCode_in     = opc;
        eu_if.RegDst        = rdst;
        eu_if.ALUSrc        = asrc;
        eu_if.PC_Plus_4_in  = pc4;
        eu_if.ReadData1_in  = a;
        eu_if.ReadData2_in  = b;
        eu_if.SignExtend_in = se;
        eu_if.Rt_in         = rt;
        eu_if.Flush         = fl;
    endtask

    // Present one instruction, hold it while Stall is high, return after it is consumed
    task automatic issue(input logic [1:0] aop, input logic [5:0] opc, input logic rdst,
                         input logic asrc, input logic [31:0] pc4, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] se, input logic [4:0] rt,
                         input logic fl);
        exp_t x;
        int   nst;
        int   exp_st;
        logic push;
        logic [4:0] dest;
        dest   = rdst ? se[15:11] : rt;
        exp_st = 0;
        push   = 1'b0;
        x.cyc  = cyc + 1;
        x.rw   = 1'b0;
        x.bt   = 1'b0;
        x.dbz  = 1'b0;
        if (!fl) begin
            if (aop == 2'b01) begin
                m_res = a + (asrc ? se : b);
                m_wr  = dest;
                x.rw  = 1'b1;
                push  = 1'b1;
            end else if (aop == 2'b11) begin
                m_tgt = pc4 + {se[29:0], 2'b00};
                if (opc == 6'b000100) x.bt = (a == b);
                else if (opc == 6'b000101) x.bt = (a != b);
                push = 1'b1;
            end else if (aop == 2'b10) begin
                m_wr = dest;
                x.rw = 1'b1;
                push = 1'b1;
                if (b == 32'd0) begin
                    m_res = 32'hFFFF_FFFF;
                    x.dbz = 1'b1;
                end else begin
                    m_res  = ref_div(a, b);
                    x.cyc  = cyc + 1 + 32;
                    exp_st = 32;
                end
            end
        end
        x.res = m_res;
        x.wr  = m_wr;
        x.tgt = m_tgt;
        if (push) sbq.push_back(x);
        drive(aop, opc, rdst, asrc, pc4, a, b, se, rt, fl);
        #1;
        nst = 0;
        while (eu_if.Stall === 1'b1 && nst < 40) begin
            nst++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", 32'(nst), 32'(exp_st));
        @(negedge clk);
    endtask

    // Abort a divide at its tenth iteration
    task automatic flush_mid_div(input logic [31:0] a, input logic [31:0] b);
        drive(2'b10, 6'b000000, 1'b0, 1'b0, 32'd0, a, b, 32'd0, 5'd17, 1'b0);
        #1;
        repeat (10) @(negedge clk);
        eu_if.Flush = 1'b1;
        #1;
        chk("stall_during_flush", {31'd0, eu_if.Stall}, 32'd0);
        @(negedge clk);
        drive(2'b00, 6'b000000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        #1;
        chk("flush_result_hold", eu_if.Result, m_res);
        chk("flush_wreg_hold",   {27'd0, eu_if.WriteReg}, {27'd0, m_wr});
        chk("flush_valid",       {31'd0, eu_if.Valid}, 32'd0);
        chk("flush_regwrite",    {31'd0, eu_if.RegWrite}, 32'd0);
        chk("flush_idle_stall",  {31'd0, eu_if.Stall}, 32'd0);
    endtask

    // Assert reset in the middle of a divide
    task automatic reset_mid_div();
        drive(2'b10, 6'b000000, 1'b0, 1'b0, 32'd0, 32'd12345, 32'd11, 32'd0, 5'd9, 1'b0);
        #1;
        repeat (5) @(negedge clk);
        drive(2'b00, 6'b000000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_result", eu_if.Result, 32'd0);
        chk("rst_mid_wreg",   {27'd0, eu_if.WriteReg}, 32'd0);
        chk("rst_mid_target", eu_if.BranchTarget, 32'd0);
        chk("rst_mid_valid",  {31'd0, eu_if.Valid}, 32'd0);
        chk("rst_mid_stall",  {31'd0, eu_if.Stall}, 32'd0);
        m_res = 32'd0;
        m_wr  = 5'd0;
        m_tgt = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0]  r_aop;
        logic [5:0]  r_opc;
        logic [31:0] r_a, r_b, r_se, r_pc;
        logic        r_fl;
        int          k;
        m_res = 32'd0;
        m_wr  = 5'd0;
        m_tgt = 32'd0;
        drive(2'b00, 6'b000000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_result",   eu_if.Result, 32'd0);
        chk("reset_wreg",     {27'd0, eu_if.WriteReg}, 32'd0);
        chk("reset_regwrite", {31'd0, eu_if.RegWrite}, 32'd0);
        chk("reset_valid",    {31'd0, eu_if.Valid}, 32'd0);
        chk("reset_taken",    {31'd0, eu_if.BranchTaken}, 32'd0);
        chk("reset_target",   eu_if.BranchTarget, 32'd0);
        chk("reset_dbz",      {31'd0, eu_if.DivByZero}, 32'd0);
        chk("reset_stall",    {31'd0, eu_if.Stall}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(2'b01, OP_ADDI, 1'b0, 1'b1, 32'd0, 32'd5, 32'd0, 32'hFFFF_FFFD, 5'd8, 1'b0);
        issue(2'b11, OP_BEQ, 1'b0, 1'b0, 32'h100, 32'd7, 32'd7, 32'd4, 5'd0, 1'b0);
        issue(2'b11, OP_BNE, 1'b0, 1'b0, 32'h100, 32'd7, 32'd7, 32'd4, 5'd0, 1'b0);
        issue(2'b10, OP_RTYPE, 1'b1, 1'b0, 32'd0, 32'd100, 32'd7, 32'h0000_1800, 5'd0, 1'b0);
        issue(2'b10, OP_RTYPE, 1'b0, 1'b0, 32'd0, 32'd55, 32'd0, 32'd0, 5'd5, 1'b0);
        issue(2'b10, OP_RTYPE, 1'b0, 1'b0, 32'd0, 32'hFFFF_FF9C, 32'd7, 32'd0, 5'd6, 1'b0);
        issue(2'b10, OP_RTYPE, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd7, 1'b0);
        issue(2'b10, OP_RTYPE, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd10, 1'b0);
        issue(2'b00, OP_RTYPE, 1'b0, 1'b0, 32'd0, 32'd1, 32'd2, 32'd3, 5'd4, 1'b0);
        flush_mid_div(32'd1000, 32'd3);
        issue(2'b01, OP_ADDI, 1'b0, 1'b1, 32'd0, 32'd40, 32'd0, 32'd2, 5'd12, 1'b0);
        issue(2'b01, OP_ADDI, 1'b0, 1'b1, 32'd0, 32'd1, 32'd0, 32'd1, 5'd13, 1'b1);

        for (int i = 0; i < 200; i++) begin
            if (i == 100) reset_mid_div();
            r_aop = 2'($urandom_range(0, 3));
            r_a   = $urandom();
            r_se  = $urandom();
            r_pc  = $urandom();
            r_fl  = ($urandom_range(0, 15) == 0);
            k     = $urandom_range(0, 4);
            r_b   = $urandom();
            if (r_aop == 2'b01) r_opc = OP_ADDI;
            else if (r_aop == 2'b11) r_opc = (k < 2) ? 6'b000100 : (k < 4) ? 6'b000101 : 6'($urandom());
            else r_opc = OP_RTYPE;
            if (r_aop == 2'b11 && k[0]) r_b = r_a;
            if (r_aop == 2'b10) begin
                if (k == 0) r_b = 32'd0;
                else if (k < 3) r_b = 32'($urandom_range(1, 1000));
            end
            issue(r_aop, r_opc, 1'($urandom()), 1'($urandom()), r_pc, r_a, r_b, r_se,
                  5'($urandom()), r_fl);
        end

        drive(2'b00, 6'b000000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
        repeat (4) @(negedge clk);
        chk("scoreboard_drain", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
